// File: rtl/keyvalue_param_if.sv
// rtl/keyvalue_param_if.sv - bus bundle for the parametrised key/value table
interface keyvalue_param_if #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
);
  logic          CYC_i;
  logic          STB_i;
  logic [1:0]    OP_i;
  logic [W-1:0]  ADR_i;
  logic [W-1:0]  DAT_i;
  logic          STALL_o;
  logic          ACK_o;
  logic [W-1:0]  DAT_o;
  logic          HIT_o;
  logic          DUP_o;
  logic          ERR_o;
  logic          FULL_o;
  logic [IW:0]   COUNT_o;
  logic [W-1:0]  LA_o;

  modport master (
    output CYC_i, STB_i, OP_i, ADR_i, DAT_i,
    input  STALL_o, ACK_o, DAT_o, HIT_o, DUP_o, ERR_o, FULL_o, COUNT_o, LA_o
  );

  modport slave (
    input  CYC_i, STB_i, OP_i, ADR_i, DAT_i,
    output STALL_o, ACK_o, DAT_o, HIT_o, DUP_o, ERR_o, FULL_o, COUNT_o, LA_o
  );
endinterface

// File: rtl/keyvalue_param.sv
// rtl/keyvalue_param.sv - DEPTH-entry key/value table with sequential scan lookup
module keyvalue_param #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  keyvalue_param_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_RESP} state_t;

  localparam logic [1:0]    OP_LOOKUP  = 2'b00;
  localparam logic [1:0]    OP_RLOOKUP = 2'b01;
  localparam logic [1:0]    OP_INSERT  = 2'b10;
  localparam logic [1:0]    OP_DELETE  = 2'b11;
  localparam logic [IW-1:0] LAST_IDX   = IW'(DEPTH - 1);
  localparam logic [IW:0]   COUNT_MAX  = (IW+1)'(DEPTH);
  localparam logic [IW:0]   COUNT_ONE  = (IW+1)'(1);

  logic [W-1:0]     key_mem [DEPTH];
  logic [W-1:0]     val_mem [DEPTH];

  state_t           state_q;
  logic [1:0]       op_q;
  logic [W-1:0]     adr_q;
  logic [W-1:0]     din_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    hit_idx_q;
  logic [IW-1:0]    free_idx_q;
  logic             hit_found_q;
  logic             free_found_q;
  logic [DEPTH-1:0] valid_q;
  logic [IW:0]      count_q;
  logic             stall_q;
  logic             ack_q;
  logic             hit_q;
  logic             dup_q;
  logic             err_q;
  logic [W-1:0]     dat_q;

  logic [W-1:0]     key_at;
  logic [W-1:0]     val_at;
  logic             match_c;
  logic             free_here;

  assign key_at    = key_mem[idx_q];
  assign val_at    = val_mem[idx_q];
  assign free_here = !valid_q[idx_q];

  // Match test for the entry under the scan pointer; reverse lookup compares values.
  always_comb begin
    match_c = 1'b0;
    if (op_q == OP_RLOOKUP) begin
      match_c = valid_q[idx_q] && (val_at == din_q);
    end else begin
      match_c = valid_q[idx_q] && (key_at == adr_q);
    end
  end

  // Table contents carry no reset; only the valid bits decide whether an entry is live.
  always_ff @(posedge sys_clk) begin
    if (state_q == S_WRITE && op_q == OP_INSERT) begin
      if (hit_found_q) begin
        val_mem[hit_idx_q] <= din_q;
      end else begin
        key_mem[free_idx_q] <= adr_q;
        val_mem[free_idx_q] <= din_q;
      end
    end
  end

  // Control FSM with registered bus outputs, valid bits and occupancy count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      adr_q        <= '0;
      din_q        <= '0;
      idx_q        <= '0;
      hit_idx_q    <= '0;
      free_idx_q   <= '0;
      hit_found_q  <= 1'b0;
      free_found_q <= 1'b0;
      valid_q      <= '0;
      count_q      <= '0;
      stall_q      <= 1'b0;
      ack_q        <= 1'b0;
      hit_q        <= 1'b0;
      dup_q        <= 1'b0;
      err_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.CYC_i && bus.STB_i) begin
            op_q         <= bus.OP_i;
            adr_q        <= bus.ADR_i;
            din_q        <= bus.DAT_i;
            idx_q        <= '0;
            hit_found_q  <= 1'b0;
            free_found_q <= 1'b0;
            stall_q      <= 1'b1;
            state_q      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (free_here && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          if (match_c) begin
            hit_found_q <= 1'b1;
            hit_idx_q   <= idx_q;
            if (op_q == OP_LOOKUP || op_q == OP_RLOOKUP) begin
              // Lookups answer straight from the scan; no table update needed.
              dat_q   <= (op_q == OP_LOOKUP) ? val_at : key_at;
              hit_q   <= 1'b1;
              dup_q   <= 1'b0;
              err_q   <= 1'b0;
              ack_q   <= bus.CYC_i;
              state_q <= S_RESP;
            end else begin
              state_q <= S_WRITE;
            end
          end else if (idx_q == LAST_IDX) begin
            // A free slot may be the last entry itself, not yet in free_found_q.
            if (op_q == OP_INSERT && (free_found_q || free_here)) begin
              state_q <= S_WRITE;
            end else begin
              dat_q   <= '0;
              hit_q   <= 1'b0;
              dup_q   <= 1'b0;
              err_q   <= 1'b1;
              ack_q   <= bus.CYC_i;
              state_q <= S_RESP;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (op_q == OP_INSERT) begin
            if (!hit_found_q && count_q != COUNT_MAX) begin
              valid_q[free_idx_q] <= 1'b1;
              count_q             <= count_q + COUNT_ONE;
            end
          end else if (op_q == OP_DELETE && hit_found_q && count_q != '0) begin
            valid_q[hit_idx_q] <= 1'b0;
            count_q            <= count_q - COUNT_ONE;
          end
          dat_q   <= hit_found_q ? W'(hit_idx_q) : W'(free_idx_q);
          hit_q   <= hit_found_q;
          dup_q   <= hit_found_q && (op_q == OP_INSERT);
          err_q   <= 1'b0;
          ack_q   <= bus.CYC_i;
          state_q <= S_RESP;
        end
        S_RESP: begin
          stall_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.STALL_o = stall_q;
  assign bus.ACK_o   = ack_q;
  assign bus.DAT_o   = dat_q;
  assign bus.LA_o    = dat_q;
  assign bus.HIT_o   = hit_q;
  assign bus.DUP_o   = dup_q;
  assign bus.ERR_o   = err_q;
  assign bus.COUNT_o = count_q;
  assign bus.FULL_o  = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_keyvalue_param.sv
// tb/tb_keyvalue_param.sv - self-checking bench for keyvalue_param against a table model
module tb_keyvalue_param;

  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [W-1:0] m_key [DEPTH];
  logic [W-1:0] m_val [DEPTH];
  bit           m_vld [DEPTH];
  int           m_cnt;

  int           last_lat;
  logic [W-1:0] last_dat;
  logic         last_hit;
  logic         last_dup;
  logic         last_err;

  keyvalue_param_if #(.W(W), .DEPTH(DEPTH)) bus ();

  keyvalue_param #(.W(W), .DEPTH(DEPTH)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_cnt = 0;
  endtask

  // One bus transaction: model decides outcome, bench drives the request and compares.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] adr, input logic [W-1:0] dat,
                       input int drop_at, input bit pulse_stb);
    int           hit_i;
    int           free_i;
    int           lat;
    int           seen;
    logic [W-1:0] e_dat;
    logic         e_hit;
    logic         e_dup;
    logic         e_err;
    hit_i  = -1;
    free_i = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_i < 0 && m_vld[i] && ((op == 2'b01) ? (m_val[i] == dat) : (m_key[i] == adr))) hit_i = i;
      if (free_i < 0 && !m_vld[i]) free_i = i;
    end
    e_dat = '0; e_hit = 1'b0; e_dup = 1'b0; e_err = 1'b0; lat = DEPTH + 1;
    case (op)
      2'b00, 2'b01: begin
        if (hit_i >= 0) begin
          e_dat = (op == 2'b00) ? m_val[hit_i] : m_key[hit_i];
          e_hit = 1'b1;
          lat   = hit_i + 2;
        end else e_err = 1'b1;
      end
      2'b10: begin
        if (hit_i >= 0) begin
          m_val[hit_i] = dat;
          e_dat = W'(hit_i); e_hit = 1'b1; e_dup = 1'b1; lat = hit_i + 3;
        end else if (free_i >= 0) begin
          m_key[free_i] = adr; m_val[free_i] = dat; m_vld[free_i] = 1'b1; m_cnt++;
          e_dat = W'(free_i); lat = DEPTH + 2;
        end else e_err = 1'b1;
      end
      default: begin
        if (hit_i >= 0) begin
          m_vld[hit_i] = 1'b0; m_cnt--;
          e_dat = W'(hit_i); e_hit = 1'b1; lat = hit_i + 3;
        end else e_err = 1'b1;
      end
    endcase

    @(negedge clk);
    check("idle_stall", bus.STALL_o, 0);
    check("idle_ack", bus.ACK_o, 0);
    bus.CYC_i = 1'b1; bus.STB_i = 1'b1; bus.OP_i = op; bus.ADR_i = adr; bus.DAT_i = dat;
    seen = 0;
    for (int k = 1; k <= DEPTH + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.STB_i = 1'b0;
        check("busy_stall", bus.STALL_o, 1);
      end
      if (pulse_stb && k == 2) bus.STB_i = 1'b1;
      if (pulse_stb && k == 3) bus.STB_i = 1'b0;
      if (drop_at != 0 && k == drop_at) bus.CYC_i = 1'b0;
      if (bus.ACK_o) begin
        seen = k;
        break;
      end
    end
    last_lat = seen;
    if (drop_at != 0) begin
      check("dropped_no_ack", seen, 0);
      check("dropped_back_idle", bus.STALL_o, 0);
    end else begin
      check("ack_cycle", seen, lat);
      last_dat = bus.DAT_o; last_hit = bus.HIT_o; last_dup = bus.DUP_o; last_err = bus.ERR_o;
      check("dat", bus.DAT_o, e_dat);
      check("hit", bus.HIT_o, e_hit);
      check("dup", bus.DUP_o, e_dup);
      check("err", bus.ERR_o, e_err);
      check("la_mirror", bus.LA_o, e_dat);
    end
    check("count", bus.COUNT_o, m_cnt);
    check("full", bus.FULL_o, (m_cnt == DEPTH));
    bus.CYC_i = 1'b0; bus.STB_i = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    bus.CYC_i = 1'b0; bus.STB_i = 1'b0; bus.OP_i = '0; bus.ADR_i = '0; bus.DAT_i = '0;
    model_clear();
    rst_n = 1'b0;
    #1;
    check("rst_stall", bus.STALL_o, 0);
    check("rst_ack", bus.ACK_o, 0);
    check("rst_dat", bus.DAT_o, 0);
    check("rst_count", bus.COUNT_o, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 8'h05, 8'h00, 0, 0);
    check("lit_empty_lookup_lat", last_lat, 9);
    check("lit_empty_lookup_err", last_err, 1);
    do_op(2'b10, 8'h05, 8'hA1, 0, 0);
    check("lit_first_insert_lat", last_lat, 10);
    check("lit_first_insert_dat", last_dat, 8'h00);
    do_op(2'b00, 8'h05, 8'h00, 0, 0);
    check("lit_lookup_lat", last_lat, 2);
    check("lit_lookup_dat", last_dat, 8'hA1);
    do_op(2'b10, 8'h05, 8'hB2, 0, 0);
    check("lit_update_dup", last_dup, 1);
    do_op(2'b01, 8'h00, 8'hB2, 0, 0);
    check("lit_rlookup_dat", last_dat, 8'h05);

    for (int i = 0; i < DEPTH - 1; i++) do_op(2'b10, 8'(8'h10 + i), 8'(8'h20 + i), 0, 0);
    check("lit_fill_count", bus.COUNT_o, DEPTH);
    check("lit_fill_full", bus.FULL_o, 1);
    do_op(2'b10, 8'h77, 8'h78, 0, 0);
    check("lit_full_insert_err", last_err, 1);
    do_op(2'b00, 8'h77, 8'h00, 0, 0);
    do_op(2'b00, 8'h16, 8'h00, 0, 0);
    do_op(2'b11, 8'h12, 8'h00, 0, 0);
    check("lit_delete_idx", last_dat, 3);
    do_op(2'b10, 8'h99, 8'h9A, 0, 0);
    check("lit_reinsert_idx", last_dat, 3);
    do_op(2'b11, 8'h42, 8'h00, 0, 0);

    do_op(2'b11, 8'h14, 8'h00, 0, 0);
    do_op(2'b10, 8'h55, 8'h66, 2, 0);
    do_op(2'b00, 8'h55, 8'h00, 0, 1);
    check("lit_dropped_insert_val", last_dat, 8'h66);

    do_op(2'b00, 8'h16, 8'h00, 0, 0);
    @(negedge clk);
    bus.CYC_i = 1'b1; bus.STB_i = 1'b1; bus.OP_i = 2'b00; bus.ADR_i = 8'h16;
    @(negedge clk);
    bus.STB_i = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_stall", bus.STALL_o, 0);
    check("arst_ack", bus.ACK_o, 0);
    check("arst_hit", bus.HIT_o, 0);
    check("arst_dat", bus.DAT_o, 0);
    check("arst_count", bus.COUNT_o, 0);
    bus.CYC_i = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b00, 8'h05, 8'h00, 0, 0);
    check("lit_after_reset_miss", last_hit, 0);

    do_op(2'b10, 8'h00, 8'h00, 0, 0);
    do_op(2'b00, 8'h00, 8'h00, 0, 0);
    check("lit_key0_hit", last_hit, 1);
    do_op(2'b01, 8'h00, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyvalue_param.md
Name: keyvalue_param

Overview:
- Parametrised successor to the 8-entry key/value store: a DEPTH-entry associative table of W-bit keys and W-bit values behind the same STB/CYC/WE-style bus handshake.
- Adds per-entry valid bits, explicit delete, in-place update, full/error reporting and an occupancy count.
- Lookup uses a sequential one-entry-per-cycle scan, so DEPTH scales without a wide parallel comparator.
- Sits as a bus slave beside the existing key/value blocks; LA_o mirrors DAT_o for the logic analyser.

Parameters:
- W, 8, key and value width in bits; must satisfy W >= IW.
- DEPTH, 8, number of table entries; must be >= 2.
- IW, $clog2(DEPTH), entry index width; derived, not overridden.

Ports:
- sys_clk  in  1  clock; all state changes on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- CYC_i  in  1  bus cycle active.
- STB_i  in  1  request strobe.
- OP_i  in  2  operation: 00 lookup by key, 01 reverse lookup by value, 10 insert/update, 11 delete.
- ADR_i  in  W  key operand.
- DAT_i  in  W  value operand (ops 01 and 10).
- STALL_o  out  1  busy; request not accepted.
- ACK_o  out  1  one-cycle completion pulse.
- DAT_o  out  W  result data.
- HIT_o  out  1  a matching valid entry was found.
- DUP_o  out  1  insert overwrote an existing key.
- ERR_o  out  1  operation failed.
- FULL_o  out  1  all entries valid.
- COUNT_o  out  IW+1  number of valid entries.
- LA_o  out  W  equals DAT_o.

Behaviour:
- Reset (asynchronous, sys_rst_n=0):
  - All valid bits cleared; COUNT_o=0; state IDLE.
  - STALL_o, ACK_o, HIT_o, DUP_o, ERR_o and DAT_o all 0.
  - Reset mid-operation aborts it with no ACK; a pending write is discarded.
- Storage: key/value contents need no reset; valid bits gate every comparison. Key 0 and value 0 are legal.
- FSM states: IDLE, SCAN, WRITE, RESP.
- IDLE:
  - STALL_o=0.
  - On CYC_i&STB_i: latch OP_i, ADR_i and DAT_i; clear idx, hit and free_found; go to SCAN.
  - STALL_o=1 from the next cycle until back in IDLE.
- SCAN (examines entry idx each cycle):
  - Match test: valid[idx] && key[idx]==ADR for ops 00/10/11; valid[idx] && val[idx]==DAT for op 01.
  - On first match: record hit_idx, then go to RESP (ops 00/01) or WRITE (ops 10/11).
  - First invalid entry seen is recorded as free_idx.
  - After idx==DEPTH-1 with no match:
    - ops 00/01/11 go to RESP (miss).
    - op 10 goes to WRITE if free_found, else to RESP with an error.
  - Lowest index wins on multiple matches.
- WRITE (one cycle):
  - Insert hit: val[hit_idx]=DAT; DUP set.
  - Insert new: key/val[free_idx] written; valid set; COUNT+1.
  - Delete hit: valid cleared; COUNT-1.
  - Then go to RESP.
- RESP (one cycle):
  - ACK_o=1 only if CYC_i is still high. If CYC_i dropped, writes still commit and no ACK is given.
  - Then go to IDLE.
- Result fields, registered and held until the next RESP:
  - op 00: DAT_o = value.
  - op 01: DAT_o = key.
  - ops 10/11: DAT_o = entry index, zero-extended.
  - Any miss or error: DAT_o = 0.
  - HIT_o: match found.
  - DUP_o: insert overwrote an existing key.
  - ERR_o: lookup miss, delete miss, or insert while full.
- Latency (accept at cycle 0, matching entry at index i):
  - Lookup hit: ACK at cycle i+2.
  - Insert/delete hit: ACK at cycle i+3.
  - Lookup/delete miss: ACK at cycle DEPTH+1.
  - New insert: ACK at cycle DEPTH+2.
  - Full insert: ACK at cycle DEPTH+1.
- Status: FULL_o = (COUNT_o==DEPTH), combinational from COUNT_o. COUNT never wraps; guarded by FULL and by the hit checks.
- Handshake: STB_i asserted while STALL_o=1 is ignored. Back-to-back requests are accepted in the IDLE cycle following RESP.

Test Plan:
- Reset, then op 00 with key 0x05: ERR_o=1, HIT_o=0, DAT_o=0, ACK at cycle DEPTH+1, COUNT_o=0.
- Insert (0x05,0xA1), then lookup key 0x05: insert gives DAT_o=0, ACK at cycle DEPTH+2, COUNT_o=1; lookup gives DAT_o=0xA1, HIT_o=1, ACK at cycle 2.
- Insert (0x05,0xB2) again: DUP_o=1, COUNT_o stays 1. Then op 01 with value 0xB2: DAT_o=0x05.
- Fill all DEPTH entries, then insert a new key: FULL_o=1, ERR_o=1, contents unchanged. Delete entry 3, re-insert: new entry lands at index 3, COUNT_o=DEPTH.
- Drop CYC_i during SCAN of an insert: no ACK_o, entry is still written and COUNT_o increments. STB_i pulses while STALL_o=1 are ignored.
- Assert sys_rst_n=0 asynchronously mid-SCAN: outputs 0 immediately, COUNT_o=0. A subsequent lookup of a previously stored key misses.
